// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, FIFO/dispatcher defaults
// and the transmit dispatcher state encoding.
package uart_pkg;

    localparam int UART_DATA_W          = 8;
    localparam int UART_DEF_DEPTH       = 16;
    localparam int UART_DEF_ACK_TIMEOUT = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_ACK,
        S_WAIT_DONE
    } tx_fsm_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x 8 register array for the transmit queue.
// Single write port, combinational head read; contents not reset.
module sync_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH  = UART_DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [UART_DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic [UART_DATA_W-1:0] rd_data
);

    logic [UART_DATA_W-1:0] r_mem [DEPTH];

    // Store accepted host bytes at the write pointer
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte queue + dispatcher feeding an 8-N-1 UART transmitter.
// Optional overflow flag: define UART_TX_FIFO_OVF_EN.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH       = UART_DEF_DEPTH,
    parameter  int ACK_TIMEOUT = UART_DEF_ACK_TIMEOUT,
    localparam int ADDR_W      = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [UART_DATA_W-1:0] wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [ADDR_W:0]        level,
    output logic                   tx_start,
    output logic [UART_DATA_W-1:0] tx_data,
    input  logic                   tx_busy
`ifdef UART_TX_FIFO_OVF_EN
    ,
    input  logic                   ovf_clr,
    output logic                   ovf
`endif
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [7:0]      TMO_LAST = 8'(ACK_TIMEOUT - 1);

    logic [ADDR_W-1:0]      r_wr_ptr;
    logic [ADDR_W-1:0]      r_rd_ptr;
    logic [ADDR_W:0]        r_count;
    logic [7:0]             r_timer;
    logic [UART_DATA_W-1:0] r_tx_data;
    tx_fsm_t                r_state;
    tx_fsm_t                w_next;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_wr_acc;
    logic                   w_pop;
    logic                   w_latch;
    logic                   w_start;
    logic                   w_timer_clr;
    logic                   w_timer_inc;
    logic [UART_DATA_W-1:0] w_head;

    assign w_full   = (r_count == FULL_CNT);
    assign w_empty  = (r_count == '0);
    assign w_wr_acc = wr_en && !w_full;
    assign w_pop    = (r_state == S_WAIT_ACK) && tx_busy;

    sync_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (w_wr_acc),
        .wr_addr (r_wr_ptr),
        .wr_data (wr_data),
        .rd_addr (r_rd_ptr),
        .rd_data (w_head)
    );

    // Pointers wrap naturally; occupancy kept in a separate 0..DEPTH counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_wr_acc && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_wr_acc) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Dispatcher next-state: launch, retry on missing ack, wait for frame end
    always_comb begin
        w_next      = r_state;
        w_latch     = 1'b0;
        w_start     = 1'b0;
        w_timer_clr = 1'b0;
        w_timer_inc = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && !tx_busy) begin
                    w_latch = 1'b1;
                    w_next  = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_start     = 1'b1;
                w_timer_clr = 1'b1;
                w_next      = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (tx_busy) begin
                    w_next = S_WAIT_DONE;
                end else if (r_timer == TMO_LAST) begin
                    w_next = S_LAUNCH;
                end else begin
                    w_timer_inc = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Dispatcher state, ack timer and held transmit byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_tx_data <= '0;
        end else begin
            r_state <= w_next;
            if (w_timer_clr) begin
                r_timer <= '0;
            end else if (w_timer_inc) begin
                r_timer <= r_timer + 8'd1;
            end
            if (w_latch) begin
                r_tx_data <= w_head;
            end
        end
    end

    assign full     = w_full;
    assign empty    = w_empty;
    assign level    = r_count;
    assign tx_start = w_start;
    assign tx_data  = r_tx_data;

`ifdef UART_TX_FIFO_OVF_EN
    logic r_ovf;

    // Sticky drop flag; a new drop outranks a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (wr_en && w_full) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo with a transmitter responder
// and a queue-based reference model of the byte stream.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int ACK   = 16;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       wr_en   = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
`ifdef UART_TX_FIFO_OVF_EN
    logic       ovf_clr = 1'b0;
    logic       ovf;
    logic       m_ovf   = 1'b0;
`endif

    // transmitter responder
    logic       manual       = 1'b0;
    logic       man_busy     = 1'b0;
    logic       ignore_start = 1'b0;
    logic       model_busy   = 1'b0;
    int         frame_len    = 8;
    int         bcnt         = 0;
    int         acc_cnt      = 0;
    int         viol         = 0;
    logic [7:0] last_sent    = 8'h00;

    // reference model
    logic [7:0] exp_q[$];
    int         mlevel    = 0;
    logic       pend_pop  = 1'b0;
    logic       force_pop = 1'b0;
    int         acc_seen  = 0;

    int checks = 0;
    int errors = 0;

    assign tx_busy = manual ? man_busy : model_busy;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .DEPTH       (DEPTH),
        .ACK_TIMEOUT (ACK)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy)
`ifdef UART_TX_FIFO_OVF_EN
        ,
        .ovf_clr  (ovf_clr),
        .ovf      (ovf)
`endif
    );

    // Transmitter: busy rises one cycle after an accepted start, lasts frame_len
    always @(posedge clk) begin
        if (tx_start && tx_busy) begin
            viol <= viol + 1;
        end
        if (bcnt > 0) begin
            bcnt       <= bcnt - 1;
            model_busy <= (bcnt > 1);
        end else if (tx_start && !manual && !ignore_start) begin
            model_busy <= 1'b1;
            bcnt       <= frame_len;
            acc_cnt    <= acc_cnt + 1;
            last_sent  <= tx_data;
        end else begin
            model_busy <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge with the given write; model updated and compared after
    task automatic cycle(input logic w, input logic [7:0] d);
        logic acc_w;
        logic pop;
`ifdef UART_TX_FIFO_OVF_EN
        logic drop;
        logic clr;
        drop = w && (mlevel >= DEPTH);
        clr  = ovf_clr;
`endif
        wr_en   = w;
        wr_data = d;
        acc_w   = w && (mlevel < DEPTH);
        pop     = pend_pop || force_pop;
        @(negedge clk);
        wr_en     = 1'b0;
        force_pop = 1'b0;
        if (acc_w) exp_q.push_back(d);
        if (pop && exp_q.size() > 0) exp_q.delete(0);
`ifdef UART_TX_FIFO_OVF_EN
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        check("ovf", ovf, m_ovf);
`endif
        pend_pop = (acc_cnt != acc_seen);
        acc_seen = acc_cnt;
        if (pend_pop) begin
            check("accept_nonempty", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("order", last_sent, exp_q[0]);
        end
        mlevel = exp_q.size();
        check("level", level, mlevel);
        check("empty", empty, mlevel == 0);
        check("full", full, mlevel == DEPTH);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || pend_pop || tx_busy) && n < 3000) begin
            cycle(1'b0, 8'h00);
            n++;
        end
        check("drain_timeout", n < 3000, 1);
        repeat (3) cycle(1'b0, 8'h00);
    endtask

    initial begin
        int a0;
        int n;
        logic [7:0] b;

        // reset
        repeat (3) @(negedge clk);
        check("rst_level", level, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 8'h00);
            check("idle_start", tx_start, 0);
            check("idle_data", tx_data, 8'h00);
        end

        // single byte: start at t+2, busy at t+3, pop seen at t+4
        frame_len = 100;
        cycle(1'b1, 8'hA5);
        check("a5_no_bypass", tx_start, 0);
        cycle(1'b0, 8'h00);
        check("a5_start", tx_start, 1);
        check("a5_data_l", tx_data, 8'hA5);
        cycle(1'b0, 8'h00);
        check("a5_start_off", tx_start, 0);
        check("a5_data_w", tx_data, 8'hA5);
        check("a5_busy", tx_busy, 1);
        cycle(1'b0, 8'h00);
        check("a5_level0", level, 0);
        drain();

        // burst of 17 with busy held: last one dropped
        manual   = 1'b1;
        man_busy = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            cycle(1'b1, 8'(i));
            if (i == 15) begin
                check("burst_full", full, 1);
                check("burst_lvl16", level, 16);
            end
        end
        check("burst_lvl_drop", level, 16);
`ifdef UART_TX_FIFO_OVF_EN
        check("burst_ovf", ovf, 1);
        ovf_clr = 1'b1;
        cycle(1'b0, 8'h00);
        ovf_clr = 1'b0;
        check("ovf_cleared", ovf, 0);
`endif
        a0        = acc_cnt;
        frame_len = $urandom_range(2, 12);
        manual    = 1'b0;
        drain();
        check("burst_frames", acc_cnt - a0, 16);

        // transmitter ignores starts: retries at t+2, t+19, t+36
        frame_len    = 10;
        ignore_start = 1'b1;
        a0           = acc_cnt;
        b            = 8'($urandom);
        cycle(1'b1, b);
        for (int k = 1; k <= 40; k++) begin
            check("retry_start", tx_start, (k == 2 || k == 19 || k == 36));
            if (k == 2 || k == 19 || k == 36) check("retry_data", tx_data, b);
            if (k < 40) cycle(1'b0, 8'h00);
        end
        check("retry_level", level, 1);
        ignore_start = 1'b0;
        n = 0;
        while (acc_cnt == a0 && n < 100) begin
            cycle(1'b0, 8'h00);
            n++;
        end
        check("retry_ack_timeout", n < 100, 1);
        drain();
        check("retry_one_pop", acc_cnt - a0, 1);

        // pop coincides with write: full -> dropped, then 15 -> queued
        manual   = 1'b1;
        man_busy = 1'b1;
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'($urandom));
        man_busy = 1'b0;
        cycle(1'b0, 8'h00);
        check("co1_start", tx_start, 1);
        check("co1_head", tx_data, exp_q[0]);
        cycle(1'b0, 8'h00);
        man_busy  = 1'b1;
        force_pop = 1'b1;
        cycle(1'b1, 8'hEE);
        check("co1_level15", level, 15);
        repeat (3) cycle(1'b0, 8'h00);
        man_busy = 1'b0;
        cycle(1'b0, 8'h00);
        check("co2_gap", tx_start, 0);
        cycle(1'b0, 8'h00);
        check("co2_start", tx_start, 1);
        check("co2_head", tx_data, exp_q[0]);
        cycle(1'b0, 8'h00);
        man_busy  = 1'b1;
        force_pop = 1'b1;
        cycle(1'b1, 8'h5C);
        check("co2_level15", level, 15);
        repeat (2) cycle(1'b0, 8'h00);
        manual = 1'b0;
        drain();

        // reset while a frame is in flight
        manual   = 1'b1;
        man_busy = 1'b1;
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'($urandom));
        man_busy = 1'b0;
        cycle(1'b0, 8'h00);
        cycle(1'b0, 8'h00);
        man_busy  = 1'b1;
        force_pop = 1'b1;
        cycle(1'b0, 8'h00);
        check("mid_level5", level, 5);
        repeat (2) cycle(1'b0, 8'h00);
        rst = 1'b1;
        #1;
        check("mid_rst_level", level, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_start", tx_start, 0);
        check("mid_rst_data", tx_data, 8'h00);
        exp_q.delete();
        mlevel   = 0;
        pend_pop = 1'b0;
`ifdef UART_TX_FIFO_OVF_EN
        m_ovf = 1'b0;
`endif
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 8'h3C);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 8'h00);
            check("post_rst_hold", tx_start, 0);
        end
        man_busy = 1'b0;
        cycle(1'b0, 8'h00);
        check("post_rst_start", tx_start, 1);
        check("post_rst_data", tx_data, 8'h3C);
        manual = 1'b0;
        drain();

        // randomized traffic with random frame lengths
        for (int i = 0; i < 600; i++) begin
            frame_len = $urandom_range(2, 14);
`ifdef UART_TX_FIFO_OVF_EN
            ovf_clr = ($urandom_range(0, 7) == 0);
`endif
            cycle($urandom_range(0, 2) != 0, 8'($urandom));
        end
`ifdef UART_TX_FIFO_OVF_EN
        ovf_clr = 1'b0;
`endif
        drain();

        check("no_start_while_busy", viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte queue and dispatcher that sits directly upstream of the 8-N-1 UART transmitter. It accepts bytes from a host-side write port into a DEPTH-entry FIFO. It then feeds them one at a time to the transmitter through its tx_start / tx_data / tx_busy handshake. The host can therefore burst bytes without watching the serial timing.

Parameters:
DEPTH, 16, FIFO entries; power of two, 2..256.
ADDR_W, $clog2(DEPTH), pointer width (derived; not overridden).
ACK_TIMEOUT, 16, cycles to wait for tx_busy after a tx_start pulse before re-pulsing; range 2..255.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
wr_en  in  1  host write strobe; one byte per cycle.
wr_data  in  8  host byte.
full  out  1  FIFO holds DEPTH entries.
empty  out  1  FIFO holds 0 entries.
level  out  ADDR_W+1  current entry count, 0..DEPTH.
tx_start  out  1  one-cycle launch pulse to transmitter.
tx_data  out  8  byte to transmitter; held stable from LAUNCH until acknowledged.
tx_busy  in  1  transmitter busy; rises one cycle after an accepted tx_start, falls after the stop bit.

Behaviour:
- Reset (async assert, sync release): pointers=0, level=0, empty=1, full=0, tx_start=0, tx_data=8'h00, FSM=IDLE, timer=0. FIFO contents are don't-care.
- Write: accepted iff wr_en && !full (registered full). When wr_en && full, the byte is dropped and no state changes. level/full/empty update the cycle after the accepted write.
- Pop happens only in WAIT_ACK on the cycle tx_busy is sampled high.
  - A simultaneous accepted write and pop leaves level unchanged.
  - A write into a full FIFO is dropped even if a pop occurs in the same cycle.
- Pointers wrap modulo DEPTH. level is computed from a DEPTH+1 counter, not from the pointer difference.
- FSM states and transitions:
  - IDLE: if !empty && !tx_busy, latch the head entry into tx_data and go to LAUNCH. Otherwise stay.
  - LAUNCH: tx_start=1 for exactly this cycle; timer<=0; go to WAIT_ACK.
  - WAIT_ACK: if tx_busy, pop and go to WAIT_DONE. Otherwise, if timer==ACK_TIMEOUT-1, go to LAUNCH (retry the same byte, no pop). Otherwise timer++.
  - WAIT_DONE: when !tx_busy, go to IDLE.
- The retry covers the transmitter's power-on window, in which it ignores tx_start.
- Minimum inter-frame gap is 2 cycles (IDLE then LAUNCH) after tx_busy falls. Bytes are sent strictly in write order.
- tx_start is never asserted while tx_busy is high. Writes into an empty FIFO are not bypassed: the first tx_start comes 2 cycles after the write is accepted (empty falls, IDLE, LAUNCH).
- Reset mid-operation: the queue is flushed and the FSM returns to IDLE. A frame already in flight in the transmitter completes on its own. IDLE's !tx_busy gate prevents overlap with it.

Optional Feature:
Macro UART_TX_FIFO_OVF_EN.
- Defined: adds port ovf_clr (in, 1) and port ovf (out, 1, reset 0).
  - ovf sets the cycle after a dropped write (wr_en && full).
  - ovf is cleared by ovf_clr.
  - If set and clear coincide, set wins.
- Undefined: neither port exists, and dropped writes are silent.

Decomposition:
- Shared package uart_pkg:
  - FSM state enum (IDLE, LAUNCH, WAIT_ACK, WAIT_DONE).
  - UART_DATA_W=8.
  - Default DEPTH and ACK_TIMEOUT constants, shared with the transmitter's frame constants.
- One natural sub-module: sync_fifo_mem, the DEPTH x 8 register array with write port and combinational head read. The dispatcher FSM stays in the top.

Test Plan:
- Reset released with FIFO empty and tx_busy=0 -> empty=1, full=0, level=0, tx_start=0, tx_data=8'h00 for 20 cycles.
- Write 8'hA5 at cycle t; model asserts busy at t+3 and holds it for 100 cycles -> tx_start high only at t+2, tx_data=8'hA5 at t+2..t+3, level back to 0 at t+4.
- Write 17 bytes 8'h00..8'h10 back-to-back while the model holds tx_busy=1 -> full=1 and level=16 after the 16th write; 8'h10 is dropped; ovf=1 if the macro is enabled. The next 16 frames emit 8'h00..8'h0F in order.
- Model ignores tx_start (busy stays 0) for 40 cycles after a write at t -> tx_start pulses at t+2, t+19, t+36 with the same byte and level stays 1. When busy is then answered, exactly one pop occurs.
- FIFO at level 16; write coincides with the pop cycle -> write dropped, level 15. In the next run, with level 15, a write coincides with the pop -> level stays 15 and the byte is queued.
- Assert rst for 1 cycle while WAIT_DONE with tx_busy=1 and level=5 -> level=0 and empty=1 immediately. No tx_start until tx_busy falls.
